// File: rtl/tmr_fault_mgr.sv
// tmr_fault_mgr
//   Supervises three redundant processing modules (PMC1..PMC3) behind a voter.
//   It runs simplex while conditions are benign and switches to TMR majority
//   voting when the link error rate or an obstacle alert rises. In TMR, a module
//   that keeps mismatching is taken offline for a resync. After two retries it is
//   isolated permanently. Faults it cannot survive drive the block to a sticky
//   failsafe.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous active-high reset
//   fault     in   3  voter mismatch flags, bit k = PMC k+1
//   err_rate  in   4  received-data error rate (unsigned)
//   alert     in   1  obstacle flag
//   en        out  3  per-module enable
//   tmr_mode  out  1  1 = majority voting, 0 = simplex pass-through
//   resync    out  3  per-module resync request
//   isolated  out  3  sticky permanent-isolation flags
//   alarm     out  1  sticky failsafe indicator
//   state_o   out  3  SIMPLEX=0 TMR=1 RESYNC=2 DEGRADED=3 FAILSAFE=4
module tmr_fault_mgr #(
    parameter int FAULT_LIM  = 4,
    parameter int RESYNC_CYC = 8,
    parameter int ERR_TH     = 8,
    parameter int QUIET_CYC  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] fault,
    input  logic [3:0] err_rate,
    input  logic       alert,
    output logic [2:0] en,
    output logic       tmr_mode,
    output logic [2:0] resync,
    output logic [2:0] isolated,
    output logic       alarm,
    output logic [2:0] state_o
);

    localparam int FW = $clog2(FAULT_LIM + 1);
    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam int RW = $clog2(RESYNC_CYC + 1);
    localparam logic [FW-1:0] C_FLIM  = FW'(FAULT_LIM);
    localparam logic [QW-1:0] C_QLAST = QW'(QUIET_CYC - 1);
    localparam logic [RW-1:0] C_RLAST = RW'(RESYNC_CYC - 1);

    typedef enum logic [2:0] {
        S_SIMPLEX  = 3'd0,
        S_TMR      = 3'd1,
        S_RESYNC   = 3'd2,
        S_DEGRADED = 3'd3,
        S_FAILSAFE = 3'd4
    } state_t;

    state_t          r_state;
    logic [2:0]      r_en;
    logic            r_tmr;
    logic [2:0]      r_rs;
    logic [2:0]      r_iso;
    logic            r_alarm;
    logic [QW-1:0]   r_quiet;
    logic [RW-1:0]   r_rs_cnt;
    logic [FW-1:0]   r_cnt   [3];
    logic [1:0]      r_retry [3];

    logic [FW-1:0]   w_cnt_next [3];
    logic [2:0]      w_hit;
    logic [1:0]      w_idx;
    logic [1:0]      w_nhit;
    logic [2:0]      w_onehot;
    logic            w_busy;
    logic            w_fail;

    assign en       = r_en;
    assign tmr_mode = r_tmr;
    assign resync   = r_rs;
    assign isolated = r_iso;
    assign alarm    = r_alarm;
    assign state_o  = r_state;

    assign w_busy = (int'({28'd0, err_rate}) >= ERR_TH) || alert;

    // Next fault-counter values; a module "reaches the limit" on the edge its
    // counter would become FAULT_LIM, so the reaction happens that same edge.
    always_comb begin
        w_hit = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            w_cnt_next[k] = '0;
            if (r_en[k] && fault[k] && (r_state != S_SIMPLEX))
                w_cnt_next[k] = (r_cnt[k] == C_FLIM) ? C_FLIM : r_cnt[k] + FW'(1);
            w_hit[k] = (w_cnt_next[k] == C_FLIM);
        end
        if (w_hit[0])      w_idx = 2'd0;
        else if (w_hit[1]) w_idx = 2'd1;
        else               w_idx = 2'd2;
        w_nhit   = {1'b0, w_hit[0]} + {1'b0, w_hit[1]} + {1'b0, w_hit[2]};
        w_onehot = 3'b001 << w_idx;
        // Illegal encodings fall into failsafe as well.
        w_fail   = ((r_state == S_TMR) && (w_nhit >= 2'd2)) ||
                   (((r_state == S_RESYNC) || (r_state == S_DEGRADED)) && (|w_hit)) ||
                   (r_state > S_FAILSAFE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_SIMPLEX;
            r_en     <= 3'b001;
            r_tmr    <= 1'b0;
            r_rs     <= '0;
            r_iso    <= '0;
            r_alarm  <= 1'b0;
            r_quiet  <= '0;
            r_rs_cnt <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                r_cnt[k]   <= '0;
                r_retry[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 3; k++)
                r_cnt[k] <= w_cnt_next[k];

            if (w_fail) begin
                r_state <= S_FAILSAFE;
                r_en    <= '0;
                r_rs    <= '0;
                r_tmr   <= 1'b0;
                r_alarm <= 1'b1;
                r_quiet <= '0;
                for (int unsigned k = 0; k < 3; k++)
                    r_cnt[k] <= '0;
            end else begin
                case (r_state)
                    S_SIMPLEX: begin
                        r_quiet <= '0;
                        if (w_busy) begin
                            r_state <= S_TMR;
                            r_en    <= 3'b111;
                            r_tmr   <= 1'b1;
                        end
                    end
                    S_TMR: begin
                        // Fault handling is checked before the quiet fallback.
                        if (|w_hit) begin
                            r_quiet       <= '0;
                            r_cnt[w_idx]  <= '0;
                            if (r_retry[w_idx] < 2'd2) begin
                                r_retry[w_idx] <= r_retry[w_idx] + 2'd1;
                                r_state  <= S_RESYNC;
                                r_rs_cnt <= '0;
                                r_rs     <= w_onehot;
                                r_en     <= ~w_onehot;
                            end else begin
                                r_state <= S_DEGRADED;
                                r_iso   <= r_iso | w_onehot;
                                r_en    <= ~(r_iso | w_onehot);
                            end
                        end else if (w_busy) begin
                            r_quiet <= '0;
                        end else if (r_quiet == C_QLAST) begin
                            r_state <= S_SIMPLEX;
                            r_en    <= 3'b001;
                            r_tmr   <= 1'b0;
                            r_quiet <= '0;
                            for (int unsigned k = 0; k < 3; k++)
                                r_cnt[k] <= '0;
                        end else begin
                            r_quiet <= r_quiet + QW'(1);
                        end
                    end
                    S_RESYNC: begin
                        r_quiet <= '0;
                        if (r_rs_cnt == C_RLAST) begin
                            r_state <= S_TMR;
                            r_rs    <= '0;
                            r_en    <= 3'b111;
                        end else begin
                            r_rs_cnt <= r_rs_cnt + RW'(1);
                        end
                    end
                    default: begin
                        r_quiet <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tmr_fault_mgr.sv
// tb_tmr_fault_mgr
//   Directed vector table for tmr_fault_mgr with default parameters, plus a
//   hand-written sequence measuring the resync pulse length.
module tb_tmr_fault_mgr;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fault;
    logic [3:0] err_rate;
    logic       alert;
    logic [2:0] en;
    logic       tmr_mode;
    logic [2:0] resync;
    logic [2:0] isolated;
    logic       alarm;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmr_fault_mgr #(
        .FAULT_LIM  (4),
        .RESYNC_CYC (8),
        .ERR_TH     (8),
        .QUIET_CYC  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fault    (fault),
        .err_rate (err_rate),
        .alert    (alert),
        .en       (en),
        .tmr_mode (tmr_mode),
        .resync   (resync),
        .isolated (isolated),
        .alarm    (alarm),
        .state_o  (state_o)
    );

    typedef struct {
        logic       r;
        logic [2:0] f;
        logic [3:0] e;
        logic       a;
        logic [2:0] xen;
        logic       xtmr;
        logic [2:0] xrs;
        logic [2:0] xiso;
        logic       xal;
        logic [2:0] xst;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [2:0] f, input logic [3:0] e,
                       input logic a, input logic [2:0] xen, input logic xtmr,
                       input logic [2:0] xrs, input logic [2:0] xiso,
                       input logic xal, input logic [2:0] xst, input int n = 1);
        vec_t v;
        v.r = r; v.f = f; v.e = e; v.a = a;
        v.xen = xen; v.xtmr = xtmr; v.xrs = xrs; v.xiso = xiso; v.xal = xal; v.xst = xst;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic step(input logic r, input logic [2:0] f, input logic [3:0] e, input logic a);
        rst = r; fault = f; err_rate = e; alert = a;
        @(posedge clk);
        #1;
    endtask

    // One RESYNC round on a module: 3 fault cycles, entry, 7 held cycles, exit.
    task automatic resync_round(input logic [2:0] f, input logic [2:0] xen_rs);
        add(0, f, 0, 1, 3'b111, 1, 3'b000, 0, 0, 1, 3);
        add(0, f, 0, 1, xen_rs, 1, f, 0, 0, 2);
        add(0, f, 0, 1, xen_rs, 1, f, 0, 0, 2, 7);
        add(0, 0, 0, 1, 3'b111, 1, 3'b000, 0, 0, 1);
    endtask

    initial begin
        int n;
        int len;
        rst = 1'b1; fault = '0; err_rate = '0; alert = 1'b0;

        // Reset values, then simplex ignoring faults and err_rate just below threshold.
        add(1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 2);
        add(0, 3'b111, 7, 0, 3'b001, 0, 0, 0, 0, 0, 3);
        // Error-rate trigger, then 16 quiet cycles back to simplex.
        add(0, 0, 9, 0, 3'b111, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 3'b111, 1, 0, 0, 0, 1, 15);
        add(0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        // Alert trigger; err_rate == threshold restarts the quiet count.
        add(0, 0, 0, 1, 3'b111, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 3'b111, 1, 0, 0, 0, 1, 10);
        add(0, 0, 8, 0, 3'b111, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 3'b111, 1, 0, 0, 0, 1, 15);
        add(0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        // Fault limit on the 16th quiet cycle wins over the fallback.
        add(0, 0, 0, 1, 3'b111, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 3'b111, 1, 0, 0, 0, 1, 12);
        add(0, 3'b001, 0, 0, 3'b111, 1, 0, 0, 0, 1, 3);
        add(0, 3'b001, 0, 0, 3'b110, 1, 3'b001, 0, 0, 2);
        add(0, 0, 0, 0, 3'b110, 1, 3'b001, 0, 0, 2, 7);
        add(0, 0, 0, 0, 3'b111, 1, 0, 0, 0, 1);
        // Interrupted fault runs never reach the limit.
        add(0, 3'b010, 0, 1, 3'b111, 1, 0, 0, 0, 1, 3);
        add(0, 3'b000, 0, 1, 3'b111, 1, 0, 0, 0, 1);
        add(0, 3'b010, 0, 1, 3'b111, 1, 0, 0, 0, 1, 3);
        add(0, 3'b000, 0, 1, 3'b111, 1, 0, 0, 0, 1);
        // Module 2: two resyncs, then isolation.
        resync_round(3'b010, 3'b101);
        resync_round(3'b010, 3'b101);
        add(0, 3'b010, 0, 1, 3'b111, 1, 0, 0, 0, 1, 3);
        add(0, 3'b010, 0, 1, 3'b101, 1, 0, 3'b010, 0, 3);
        // Degraded: isolated faults ignored, no fallback on quiet.
        add(0, 3'b010, 0, 0, 3'b101, 1, 0, 3'b010, 0, 3, 20);
        add(0, 3'b001, 9, 0, 3'b101, 1, 0, 3'b010, 0, 3, 3);
        add(0, 3'b001, 9, 0, 3'b000, 0, 0, 3'b010, 1, 4);
        add(0, 3'b000, 15, 1, 3'b000, 0, 0, 3'b010, 1, 4, 5);
        add(1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        // Two modules at the limit together -> failsafe, sticky.
        add(0, 0, 9, 0, 3'b111, 1, 0, 0, 0, 1);
        add(0, 3'b011, 0, 1, 3'b111, 1, 0, 0, 0, 1, 3);
        add(0, 3'b011, 0, 1, 3'b000, 0, 0, 0, 1, 4);
        add(0, 0, 9, 0, 3'b000, 0, 0, 0, 1, 4, 4);
        add(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 4, 20);
        add(1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        // Reset in the 4th resync cycle.
        add(0, 0, 9, 0, 3'b111, 1, 0, 0, 0, 1);
        add(0, 3'b100, 0, 1, 3'b111, 1, 0, 0, 0, 1, 3);
        add(0, 3'b100, 0, 1, 3'b011, 1, 3'b100, 0, 0, 2);
        add(0, 0, 0, 1, 3'b011, 1, 3'b100, 0, 0, 2, 2);
        add(1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0);
        // Retry count was cleared: module 3 gets two fresh resyncs.
        add(0, 0, 9, 0, 3'b111, 1, 0, 0, 0, 1);
        resync_round(3'b100, 3'b011);
        add(0, 3'b100, 0, 1, 3'b111, 1, 0, 0, 0, 1, 3);
        add(0, 3'b100, 0, 1, 3'b011, 1, 3'b100, 0, 0, 2);
        // Enabled module hitting the limit during resync -> failsafe.
        add(0, 3'b001, 0, 1, 3'b011, 1, 3'b100, 0, 0, 2, 3);
        add(0, 3'b001, 0, 1, 3'b000, 0, 0, 0, 1, 4);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].r, vq[i].f, vq[i].e, vq[i].a);
            checks++;
            if ({en, tmr_mode, resync, isolated, alarm, state_o} !==
                {vq[i].xen, vq[i].xtmr, vq[i].xrs, vq[i].xiso, vq[i].xal, vq[i].xst}) begin
                errors++;
                $display("FAIL vec%0d got en=%b tmr=%b rs=%b iso=%b al=%b st=%0d exp en=%b tmr=%b rs=%b iso=%b al=%b st=%0d",
                         i, en, tmr_mode, resync, isolated, alarm, state_o,
                         vq[i].xen, vq[i].xtmr, vq[i].xrs, vq[i].xiso, vq[i].xal, vq[i].xst);
            end
        end

        // Resync pulse length measured directly.
        step(1, 0, 0, 0);
        step(0, 0, 9, 0);
        n = 0;
        while (resync == 3'b000 && n < 10) begin
            step(0, 3'b010, 0, 1);
            n++;
        end
        checks++;
        if (resync !== 3'b010 || n != 4) begin
            errors++;
            $display("FAIL rs_entry got rs=%b after %0d cycles exp rs=010 after 4", resync, n);
        end
        len = 1;
        while (resync == 3'b010 && len < 20) begin
            step(0, 0, 0, 1);
            if (resync == 3'b010) len++;
        end
        checks++;
        if (len != 8) begin
            errors++;
            $display("FAIL rs_len got %0d exp 8", len);
        end
        checks++;
        if (state_o !== 3'd1 || en !== 3'b111 || resync !== 3'b000) begin
            errors++;
            $display("FAIL rs_exit got st=%0d en=%b rs=%b exp st=1 en=111 rs=000", state_o, en, resync);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
